// File: rtl/bounce_stim_gen.sv
// Bouncy push-button stimulus generator: LFSR-driven press/release sequences with
// contact bounce on one of NCH lines, plus a golden debounced vector and edge events.
module bounce_stim_gen #(
    parameter int          NCH        = 5,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          IDLE_W     = 10,
    parameter int          BOUNCE_MAX = 3,
    parameter int          SEG_W      = 3,
    parameter int          STABLE     = 16,
    parameter int          HOLD_MIN   = 64,
    parameter int          HOLD_W     = 8,
    localparam int         CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           start,
    output logic [NCH-1:0] btn,
    output logic [NCH-1:0] clean,
    output logic           busy,
    output logic           press_evt,
    output logic           release_evt,
    output logic [CW-1:0]  chan_idx
);

    localparam logic [15:0]    SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]    LFSR_MASK = 16'hB400;
    localparam logic           LVL_I     = ACTIVE_LOW;
    localparam logic [NCH-1:0] IDLE_LVL  = {NCH{LVL_I}};
    localparam logic [15:0]    STABLE16  = 16'(STABLE);
    localparam logic [15:0]    HOLD16    = 16'(HOLD_MIN);
    localparam logic [3:0]     NMAX      = 4'(BOUNCE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_ON,
        S_SETTLE_ON,
        S_HOLD,
        S_BOUNCE_OFF,
        S_SETTLE_OFF
    } state_t;

    state_t          state_q;
    logic [15:0]     lfsr_q;
    logic [15:0]     lfsr_d;
    logic [15:0]     cnt_q;
    logic [4:0]      brem_q;
    logic [CW-1:0]   chan_q;
    logic [NCH-1:0]  btn_q;
    logic [NCH-1:0]  clean_q;
    logic            busy_q;
    logic            press_q;
    logic            release_q;

    // Draws taken from the current (pre-step) LFSR value
    logic [3:0]      n_draw;
    logic [4:0]      brem_draw;
    logic [15:0]     seg_len;
    logic [15:0]     hold_len;
    logic [8:0]      ch_full;
    logic [CW-1:0]   ch_draw;
    logic            trig;
    logic            cnt_last;
    logic [NCH-1:0]  mask_cur;
    logic [NCH-1:0]  mask_new;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_MASK;
        end
        n_draw    = (lfsr_q[7:4] > NMAX) ? NMAX : lfsr_q[7:4];
        brem_draw = {n_draw, 1'b0};
        seg_len   = 16'd1 + 16'(lfsr_q[SEG_W-1:0]);
        hold_len  = HOLD16 + 16'(lfsr_q[HOLD_W-1:0]);
        ch_full   = {1'b0, lfsr_q[15:8]} % 9'(NCH);
        ch_draw   = CW'(ch_full);
        trig      = start || (lfsr_q[IDLE_W-1:0] == '0);
        cnt_last  = (cnt_q == 16'd1);
        mask_cur  = NCH'(1) << chan_q;
        mask_new  = NCH'(1) << ch_draw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            cnt_q     <= 16'd0;
            brem_q    <= 5'd0;
            chan_q    <= '0;
            btn_q     <= IDLE_LVL;
            clean_q   <= '0;
            busy_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (en) begin
                lfsr_q <= lfsr_d;
                case (state_q)
                    S_IDLE: begin
                        if (trig) begin
                            chan_q <= ch_draw;
                            btn_q  <= IDLE_LVL ^ mask_new;
                            busy_q <= 1'b1;
                            brem_q <= brem_draw;
                            if (n_draw == 4'd0) begin
                                cnt_q   <= STABLE16;
                                state_q <= S_SETTLE_ON;
                            end else begin
                                cnt_q   <= seg_len;
                                state_q <= S_BOUNCE_ON;
                            end
                        end
                    end
                    S_BOUNCE_ON, S_BOUNCE_OFF: begin
                        if (cnt_last) begin
                            btn_q  <= btn_q ^ mask_cur;
                            brem_q <= brem_q - 5'd1;
                            // An even number of toggles always lands back on the target level
                            if (brem_q == 5'd1) begin
                                cnt_q   <= STABLE16;
                                state_q <= (state_q == S_BOUNCE_ON) ? S_SETTLE_ON : S_SETTLE_OFF;
                            end else begin
                                cnt_q <= seg_len;
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_SETTLE_ON: begin
                        if (cnt_last) begin
                            clean_q <= mask_cur;
                            press_q <= 1'b1;
                            cnt_q   <= hold_len;
                            state_q <= S_HOLD;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_HOLD: begin
                        if (cnt_last) begin
                            btn_q  <= IDLE_LVL;
                            brem_q <= brem_draw;
                            if (n_draw == 4'd0) begin
                                cnt_q   <= STABLE16;
                                state_q <= S_SETTLE_OFF;
                            end else begin
                                cnt_q   <= seg_len;
                                state_q <= S_BOUNCE_OFF;
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_SETTLE_OFF: begin
                        if (cnt_last) begin
                            clean_q   <= '0;
                            release_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign btn         = btn_q;
    assign clean       = clean_q;
    assign busy        = busy_q;
    assign press_evt   = press_q;
    assign release_evt = release_q;
    assign chan_idx    = chan_q;

endmodule
